// File: rtl/mvm_arbiter.sv
// mvm_arbiter: shares one matrix-vector engine between two clients, one whole job at a time,
// with round-robin arbitration between jobs.
module mvm_arbiter #(
    parameter int WIDTH     = 12,
    parameter int IN_WORDS  = 20,
    parameter int OUT_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c0_input_valid,
    output logic               c0_input_ready,
    input  logic [WIDTH-1:0]   c0_input_data,
    output logic               c0_output_valid,
    input  logic               c0_output_ready,
    output logic [2*WIDTH-1:0] c0_output_data,
    input  logic               c1_input_valid,
    output logic               c1_input_ready,
    input  logic [WIDTH-1:0]   c1_input_data,
    output logic               c1_output_valid,
    input  logic               c1_output_ready,
    output logic [2*WIDTH-1:0] c1_output_data,
    output logic               eng_input_valid,
    input  logic               eng_input_ready,
    output logic [WIDTH-1:0]   eng_input_data,
    input  logic               eng_output_valid,
    output logic               eng_output_ready,
    input  logic [2*WIDTH-1:0] eng_output_data,
    output logic               grant,
    output logic               busy,
    output logic [7:0]         jobs_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam int ICW = $clog2(IN_WORDS + 1);
    localparam int OCW = $clog2(OUT_WORDS + 1);

    logic [1:0]     state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_grant_q, last_grant_d;
    logic           busy_q, busy_d;
    logic [ICW-1:0] in_cnt_q, in_cnt_d;
    logic [OCW-1:0] out_cnt_q, out_cnt_d;
    logic [7:0]     jobs_done_q, jobs_done_d;
    logic           in_load, in_drain, g_in_valid, g_out_ready;
    logic           in_hs, out_hs, in_last, out_last;

    assign in_load     = state_q == LOAD;
    assign in_drain    = state_q == DRAIN;
    assign g_in_valid  = grant_q ? c1_input_valid : c0_input_valid;
    assign g_out_ready = grant_q ? c1_output_ready : c0_output_ready;

    // Every handshake path is a pure pass-through gated by state and grant
    assign eng_input_valid  = in_load & g_in_valid;
    assign eng_input_data   = grant_q ? c1_input_data : c0_input_data;
    assign c0_input_ready   = in_load & ~grant_q & eng_input_ready;
    assign c1_input_ready   = in_load & grant_q & eng_input_ready;
    assign eng_output_ready = in_drain & g_out_ready;
    assign c0_output_valid  = in_drain & ~grant_q & eng_output_valid;
    assign c1_output_valid  = in_drain & grant_q & eng_output_valid;
    assign c0_output_data   = eng_output_data;
    assign c1_output_data   = eng_output_data;

    assign in_hs    = eng_input_valid & eng_input_ready;
    assign out_hs   = eng_output_valid & eng_output_ready;
    assign in_last  = in_cnt_q == ICW'(IN_WORDS - 1);
    assign out_last = out_cnt_q == OCW'(OUT_WORDS - 1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        jobs_done_d  = jobs_done_q;
        case (state_q)
            IDLE: if (c0_input_valid | c1_input_valid) begin
                grant_d = (c0_input_valid & c1_input_valid) ? ~last_grant_q : c1_input_valid;
                state_d = LOAD;
            end
            LOAD: if (in_hs) begin
                in_cnt_d = in_last ? '0 : in_cnt_q + ICW'(1);
                state_d  = in_last ? DRAIN : LOAD;
            end
            DRAIN: if (out_hs) begin
                out_cnt_d = out_last ? '0 : out_cnt_q + OCW'(1);
                if (out_last) begin
                    last_grant_d = grant_q;
                    jobs_done_d  = jobs_done_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // last_grant resets to 1 so client 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            jobs_done_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign jobs_done = jobs_done_q;
endmodule

// File: tb/tb_mvm_arbiter.sv
// tb_mvm_arbiter: randomized bench for mvm_arbiter with a behavioural engine and a
// job-level reference model of arbitration, routing and results.
module tb_mvm_arbiter;
    localparam int W  = 12;
    localparam int IW = 20;
    localparam int OW = 4;

    logic           clk = 0, reset = 1;
    logic           c0_input_valid = 0, c0_input_ready, c0_output_valid, c0_output_ready = 1;
    logic [W-1:0]   c0_input_data = '0;
    logic [2*W-1:0] c0_output_data;
    logic           c1_input_valid = 0, c1_input_ready, c1_output_valid, c1_output_ready = 1;
    logic [W-1:0]   c1_input_data = '0;
    logic [2*W-1:0] c1_output_data;
    logic           eng_input_valid, eng_input_ready = 1, eng_output_valid = 0, eng_output_ready;
    logic [W-1:0]   eng_input_data;
    logic [2*W-1:0] eng_output_data = '0;
    logic           grant, busy;
    logic [7:0]     jobs_done;

    mvm_arbiter #(.WIDTH(W), .IN_WORDS(IW), .OUT_WORDS(OW)) dut (
        .clk(clk), .reset(reset),
        .c0_input_valid(c0_input_valid), .c0_input_ready(c0_input_ready), .c0_input_data(c0_input_data),
        .c0_output_valid(c0_output_valid), .c0_output_ready(c0_output_ready), .c0_output_data(c0_output_data),
        .c1_input_valid(c1_input_valid), .c1_input_ready(c1_input_ready), .c1_input_data(c1_input_data),
        .c1_output_valid(c1_output_valid), .c1_output_ready(c1_output_ready), .c1_output_data(c1_output_data),
        .eng_input_valid(eng_input_valid), .eng_input_ready(eng_input_ready), .eng_input_data(eng_input_data),
        .eng_output_valid(eng_output_valid), .eng_output_ready(eng_output_ready), .eng_output_data(eng_output_data),
        .grant(grant), .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [W-1:0]   cq0[$], cq1[$], tx0[$], tx1[$], eng_log[$], e_words[$];
    logic [2*W-1:0] e_out[$], rx0[$], rx1[$];
    logic           grant_log[$];
    bit vbub = 0, obub = 0, ebub = 0;
    bit m_active = 0, m_g = 0, m_last = 1, busy_prev = 0;
    int m_in = 0, m_out = 0, m_jobs = 0;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Result row r of a job: 4x4 row-major matrix (words 0..15) times vector (words 16..19)
    function automatic logic [2*W-1:0] ref_row(input bit cl, input int job, input int r);
        int acc, b;
        acc = 0;
        b = job * IW;
        for (int c = 0; c < 4; c++)
            acc += cl ? sx(tx1[b + r*4 + c]) * sx(tx1[b + 16 + c]) : sx(tx0[b + r*4 + c]) * sx(tx0[b + 16 + c]);
        return (2*W)'(acc);
    endfunction

    task automatic drive();
        c0_input_valid  = (cq0.size() > 0) && (!vbub || $urandom_range(1) == 1);
        c0_input_data   = (cq0.size() > 0) ? cq0[0] : W'($urandom);
        c1_input_valid  = (cq1.size() > 0) && (!vbub || $urandom_range(1) == 1);
        c1_input_data   = (cq1.size() > 0) ? cq1[0] : W'($urandom);
        c0_output_ready = obub ? 1'($urandom_range(1)) : 1'b1;
        c1_output_ready = obub ? 1'($urandom_range(1)) : 1'b1;
        eng_input_ready = ebub ? 1'($urandom_range(1)) : 1'b1;
        eng_output_valid = (e_out.size() > 0) && (!ebub || $urandom_range(1) == 1);
        eng_output_data  = (e_out.size() > 0) ? e_out[0] : (2*W)'($urandom);
    endtask

    // One clock: check and observe at the negedge, then drive new inputs just after the posedge
    task automatic tick();
        logic gv, gor;
        logic [5:0] act, want;
        int k, acc;
        @(negedge clk);
        if (reset) begin
            m_active = 0; m_g = 0; m_last = 1; m_in = 0; m_out = 0; m_jobs = 0; busy_prev = 0;
            e_words.delete(); e_out.delete();
        end else begin
            gv  = m_g ? c1_input_valid : c0_input_valid;
            gor = m_g ? c1_output_ready : c0_output_ready;
            act = {c0_input_ready, c1_input_ready, c0_output_valid, c1_output_valid, eng_input_valid, eng_output_ready};
            want = !m_active ? 6'b0 :
                   (m_in < IW) ? {!m_g && eng_input_ready, m_g && eng_input_ready, 1'b0, 1'b0, gv, 1'b0} :
                                 {1'b0, 1'b0, !m_g && eng_output_valid, m_g && eng_output_valid, 1'b0, gor};
            checks += 4;
            if (act !== want) begin errors++; $display("FAIL ctl t=%0t got=%b want=%b", $time, act, want); end
            if (busy !== m_active) begin errors++; $display("FAIL busy t=%0t got=%b want=%b", $time, busy, m_active); end
            if (jobs_done !== 8'(m_jobs)) begin errors++; $display("FAIL jobs_done t=%0t got=%0d want=%0d", $time, jobs_done, 8'(m_jobs)); end
            if ({c0_output_data, c1_output_data} !== {2{eng_output_data}}) begin
                errors++; $display("FAIL out_data t=%0t got=%h/%h want=%h", $time, c0_output_data, c1_output_data, eng_output_data);
            end
            if (m_active) begin
                checks++;
                if (grant !== m_g) begin errors++; $display("FAIL grant t=%0t got=%b want=%b", $time, grant, m_g); end
            end
            if (m_active && m_in < IW && gv) begin
                checks++;
                if (eng_input_data !== (m_g ? c1_input_data : c0_input_data)) begin
                    errors++; $display("FAIL eng_data t=%0t got=%h want=%h", $time, eng_input_data, m_g ? c1_input_data : c0_input_data);
                end
            end
            if (busy && !busy_prev) grant_log.push_back(grant);
            busy_prev = busy;
            if (c0_input_valid && c0_input_ready) tx0.push_back(cq0.pop_front());
            if (c1_input_valid && c1_input_ready) tx1.push_back(cq1.pop_front());
            if (eng_input_valid && eng_input_ready) begin
                eng_log.push_back(eng_input_data);
                e_words.push_back(eng_input_data);
                if (e_words.size() == IW) begin
                    for (int r = 0; r < OW; r++) begin
                        acc = 0;
                        for (int c = 0; c < 4; c++) acc += sx(e_words[r*4 + c]) * sx(e_words[16 + c]);
                        e_out.push_back((2*W)'(acc));
                    end
                    e_words.delete();
                end
            end
            if (eng_output_valid && eng_output_ready && e_out.size() > 0) void'(e_out.pop_front());
            if (c0_output_valid && c0_output_ready) begin
                k = rx0.size(); checks++;
                if (c0_output_data !== ref_row(0, k / OW, k % OW)) begin
                    errors++; $display("FAIL c0_result #%0d got=%h want=%h", k, c0_output_data, ref_row(0, k / OW, k % OW));
                end
                rx0.push_back(c0_output_data);
            end
            if (c1_output_valid && c1_output_ready) begin
                k = rx1.size(); checks++;
                if (c1_output_data !== ref_row(1, k / OW, k % OW)) begin
                    errors++; $display("FAIL c1_result #%0d got=%h want=%h", k, c1_output_data, ref_row(1, k / OW, k % OW));
                end
                rx1.push_back(c1_output_data);
            end
            if (!m_active) begin
                if (c0_input_valid || c1_input_valid) begin
                    m_g = (c0_input_valid && c1_input_valid) ? !m_last : c1_input_valid;
                    m_active = 1; m_in = 0; m_out = 0;
                end
            end else if (m_in < IW) begin
                if (gv && eng_input_ready) m_in++;
            end else if (eng_output_valid && gor) begin
                m_out++;
                if (m_out == OW) begin m_active = 0; m_last = m_g; m_jobs++; end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_jobs(input int n, input int budget);
        int k = 0;
        while (m_jobs < n && k < budget) begin tick(); k++; end
        checks++;
        if (m_jobs < n) begin errors++; $display("FAIL timeout jobs got=%0d want=%0d", m_jobs, n); end
    endtask

    task automatic do_reset();
        reset = 1;
        cq0.delete(); cq1.delete(); tx0.delete(); tx1.delete(); rx0.delete(); rx1.delete();
        eng_log.delete(); grant_log.delete();
        vbub = 0; obub = 0; ebub = 0;
        drive();
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic push_words(input bit cl, input int n);
        for (int i = 0; i < n; i++) if (cl) cq1.push_back(W'($urandom)); else cq0.push_back(W'($urandom));
    endtask

    task automatic test_reset();
        reset = 1;
        push_words(0, IW);
        drive();
        tick(); tick();
        checks += 4;
        if (busy !== 1'b0 || grant !== 1'b0) begin errors++; $display("FAIL rst_status got=%b%b want=00", busy, grant); end
        if (jobs_done !== 8'd0) begin errors++; $display("FAIL rst_jobs got=%0d want=0", jobs_done); end
        if ({c0_input_ready, c1_input_ready, eng_input_valid} !== 3'b0) begin
            errors++; $display("FAIL rst_ready got=%b want=000", {c0_input_ready, c1_input_ready, eng_input_valid});
        end
        if ({c0_output_valid, c1_output_valid, eng_output_ready} !== 3'b0) begin
            errors++; $display("FAIL rst_outv got=%b want=000", {c0_output_valid, c1_output_valid, eng_output_ready});
        end
        reset = 0;
        tick();
        checks++;
        if ({busy, grant} !== 2'b10) begin errors++; $display("FAIL first_grant got=%b want=10", {busy, grant}); end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < IW; i++) cq0.push_back(W'(i + 1));
        drive();
        run_jobs(1, 200);
        checks += 4;
        if (eng_log.size() != IW) begin errors++; $display("FAIL single_eng_count got=%0d want=%0d", eng_log.size(), IW); end
        for (int i = 0; i < eng_log.size(); i++) begin
            checks++;
            if (eng_log[i] !== W'(i + 1)) begin errors++; $display("FAIL single_eng_word%0d got=%0d want=%0d", i, eng_log[i], i + 1); end
        end
        if (rx0.size() != OW || rx1.size() != 0) begin errors++; $display("FAIL single_rx got=%0d/%0d want=%0d/0", rx0.size(), rx1.size(), OW); end
        if (jobs_done !== 8'd1) begin errors++; $display("FAIL single_jobs got=%0d want=1", jobs_done); end
        if (grant !== 1'b0) begin errors++; $display("FAIL single_grant got=%b want=0", grant); end
    endtask

    task automatic test_tie();
        do_reset();
        push_words(0, 2 * IW);
        push_words(1, 2 * IW);
        drive();
        run_jobs(4, 400);
        checks += 2;
        if (grant_log.size() != 4) begin errors++; $display("FAIL tie_jobs got=%0d want=4", grant_log.size()); end
        else begin
            checks += 3;
            if (grant_log[0] !== 1'b0) begin errors++; $display("FAIL tie_job0 got=%b want=0", grant_log[0]); end
            if (grant_log[1] !== 1'b1) begin errors++; $display("FAIL tie_job1 got=%b want=1", grant_log[1]); end
            if (grant_log[2] !== 1'b0) begin errors++; $display("FAIL tie_job2 got=%b want=0", grant_log[2]); end
        end
        if (rx0.size() != 2 * OW || rx1.size() != 2 * OW) begin
            errors++; $display("FAIL tie_rx got=%0d/%0d want=%0d/%0d", rx0.size(), rx1.size(), 2 * OW, 2 * OW);
        end
    endtask

    task automatic test_stall();
        int k = 0, bad = 0;
        do_reset();
        push_words(0, IW);
        push_words(1, IW);
        drive();
        while (m_jobs < 1 && k < 200) begin
            tick(); k++;
            if (m_active && !m_g && c1_input_ready) bad++;
        end
        checks += 3;
        if (bad != 0 || m_jobs != 1) begin errors++; $display("FAIL stall_c1_ready got=%0d cycles want=0 (jobs=%0d)", bad, m_jobs); end
        if (busy !== 1'b0) begin errors++; $display("FAIL stall_gap got=%b want=0", busy); end
        tick();
        if ({busy, grant} !== 2'b11) begin errors++; $display("FAIL stall_regrant got=%b want=11", {busy, grant}); end
        run_jobs(2, 200);
    endtask

    task automatic test_bubbles();
        int bad = 0;
        do_reset();
        vbub = 1; obub = 1; ebub = 1;
        push_words(0, 3 * IW);
        drive();
        run_jobs(3, 3000);
        checks += 3;
        if (eng_log.size() != 3 * IW || tx0.size() != 3 * IW) begin
            errors++; $display("FAIL bub_in_count got=%0d/%0d want=%0d", eng_log.size(), tx0.size(), 3 * IW);
        end
        for (int i = 0; i < eng_log.size() && i < tx0.size(); i++) if (eng_log[i] !== tx0[i]) bad++;
        if (bad != 0) begin errors++; $display("FAIL bub_order got=%0d mismatched want=0", bad); end
        if (rx0.size() != 3 * OW) begin errors++; $display("FAIL bub_out_count got=%0d want=%0d", rx0.size(), 3 * OW); end
    endtask

    task automatic test_random_mix();
        do_reset();
        vbub = 1; obub = 1; ebub = 1;
        push_words(0, 3 * IW);
        push_words(1, 3 * IW);
        drive();
        run_jobs(6, 5000);
        checks++;
        if (rx0.size() != 3 * OW || rx1.size() != 3 * OW) begin
            errors++; $display("FAIL mix_rx got=%0d/%0d want=%0d/%0d", rx0.size(), rx1.size(), 3 * OW, 3 * OW);
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        do_reset();
        push_words(1, 2 * IW);
        drive();
        run_jobs(1, 200);
        while (eng_log.size() < IW + 10 && k < 200) begin tick(); k++; end
        checks += 4;
        if ({busy, grant} !== 2'b11 || eng_log.size() != IW + 10) begin
            errors++; $display("FAIL ar_pre got=%b words=%0d want=11 words=%0d", {busy, grant}, eng_log.size(), IW + 10);
        end
        #2 reset = 1;
        #1;
        if ({busy, grant} !== 2'b00) begin errors++; $display("FAIL ar_status got=%b want=00", {busy, grant}); end
        if (jobs_done !== 8'd0) begin errors++; $display("FAIL ar_jobs got=%0d want=0", jobs_done); end
        if ({c1_input_ready, eng_input_valid} !== 2'b00) begin
            errors++; $display("FAIL ar_ctl got=%b want=00", {c1_input_ready, eng_input_valid});
        end
        cq1.delete(); tx1.delete(); rx1.delete(); eng_log.delete();
        tick(); tick();
        reset = 0;
        push_words(1, IW);
        drive();
        run_jobs(1, 200);
        checks += 2;
        if ({jobs_done, grant} !== {8'd1, 1'b1}) begin errors++; $display("FAIL ar_after got=%0d/%b want=1/1", jobs_done, grant); end
        if (rx1.size() != OW || eng_log.size() != IW) begin
            errors++; $display("FAIL ar_counts got=%0d/%0d want=%0d/%0d", rx1.size(), eng_log.size(), OW, IW);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0, low = 0, gaps = 0;
        bit prev = 0, started = 0;
        do_reset();
        push_words(0, 256 * IW);
        drive();
        while (m_jobs < 256 && k < 10000) begin
            tick(); k++;
            if (busy && !prev && started) begin
                checks++; gaps++;
                if (low != 1) begin errors++; $display("FAIL b2b_gap job%0d got=%0d want=1", m_jobs, low); end
            end
            if (busy) begin started = 1; low = 0; end else low++;
            prev = busy;
        end
        checks += 3;
        if (m_jobs != 256 || gaps != 255) begin errors++; $display("FAIL b2b_jobs got=%0d/%0d want=256/255", m_jobs, gaps); end
        if (jobs_done !== 8'd0) begin errors++; $display("FAIL b2b_wrap got=%0d want=0", jobs_done); end
        tick();
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_stall();
        test_bubbles();
        test_random_mix();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
